arm_mc_fsm: RTL and testbench
=============================

// Module: arm_mc_fsm
// PURPOSE
//  Main sequencing FSM for the multicycle ARM core. Decodes Op/Funct and steps the shared
//  ALU, register file, instruction register and unified memory through FETCH..writeback.
//  Supports a memory ready handshake with a wait timeout. Emits unconditional strobes
//  (RegW, MemW, Branch) to the condition-logic block, which gates them with the cond check.
// PARAMETERS
//  MEM_TIMEOUT  15  max cycles waiting for mem_ready in one memory state; 0 = no timeout
// PORTS
//  clk        in   1  core clock
//  reset      in   1  asynchronous, active-low reset
//  Op         in   2  Instr[27:26]
//  Funct      in   6  Instr[25:20]
//  mem_ready  in   1  memory completes the current access this cycle
//  mem_req    out  1  memory access request (FETCH/MEMREAD/MEMWRITE)
//  IRWrite    out  1  load instruction register
//  NextPC     out  1  PC <= Result (PC+4 in FETCH)
//  AdrSrc     out  1  memory address: 0 = PC, 1 = Result
//  ALUSrcA    out  1  0 = RD1 reg, 1 = PC
//  ALUSrcB    out  2  00 = RD2 reg, 01 = ExtImm, 10 = const 4
//  ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
//  ALUOp      out  1  1 = ALU decoder uses Funct, 0 = ADD
//  RegW       out  1  register write (unconditional)
//  MemW       out  1  memory write (unconditional)
//  Branch     out  1  branch write of PC (unconditional)
//  instr_done out  1  1-cycle pulse on the transition back to FETCH
//  illegal    out  1  1-cycle pulse: Op=11 decoded
//  fault      out  1  sticky: memory timeout occurred
//  state      out  4  current state code (debug)
// BEHAVIOUR
//  - States/codes: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWRITE 4, MEMWB 5,
//    EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, FAULT 15. Moore decode unless noted.
//  - reset low: state<=FETCH, wait counter<=0, immediately (async); while low, mem_req,
//    IRWrite, NextPC, RegW, MemW, Branch, instr_done, illegal, fault forced 0; others 0.
//  - Unlisted outputs are 0 in every state.
//  - FETCH: mem_req=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10; IRWrite=NextPC=
//    mem_ready (Mealy). mem_ready -> DECODE, else stay.
//  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Op=01 -> MEMADR; Op=00 & !Funct[5]
//    -> EXECR; Op=00 & Funct[5] -> EXECI; Op=10 -> BRANCH; Op=11 -> FETCH, illegal=1,
//    instr_done=0.
//  - MEMADR: ALUSrcB=01. Funct[0] -> MEMREAD else MEMWRITE.
//  - MEMREAD: mem_req=1, AdrSrc=1; mem_ready -> MEMWB. MEMWB: ResultSrc=01, RegW=1 -> FETCH.
//  - MEMWRITE: mem_req=1, AdrSrc=1, MemW=1 held all wait cycles; mem_ready -> FETCH.
//  - EXECR: ALUOp=1 -> ALUWB. EXECI: ALUSrcB=01, ALUOp=1 -> ALUWB.
//  - ALUWB: ResultSrc=00, RegW=1 -> FETCH. BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1 -> FETCH.
//  - instr_done=1 in the last cycle of MEMWB, MEMWRITE (with mem_ready), ALUWB, BRANCH.
//  - Wait counter: cleared on entry to FETCH/MEMREAD/MEMWRITE; +1 each cycle there with
//    mem_ready=0. If MEM_TIMEOUT>0, counter==MEM_TIMEOUT-1 and mem_ready=0 -> FAULT
//    (ready on that cycle wins). Width $clog2(MEM_TIMEOUT+1), never wraps.
//  - FAULT: fault=1, all strobes 0, mem_req=0; exits only via reset.
//  - Op/Funct sampled only in DECODE/MEMADR; IR must be stable after FETCH.
// TESTING
//  - ADD reg (Op=00,Funct=001000), ready=1: FETCH,DECODE,EXECR,ALUWB,FETCH; RegW only in ALUWB; 1 instr_done.
//  - LDR (Op=01,Funct=011001), ready low 3 cycles in MEMREAD: MEMREAD 4 cycles, AdrSrc=1; MEMWB RegW=1, ResultSrc=01.
//  - STR (Op=01,Funct=011000): MemW=1 only in MEMWRITE; RegW never; instr_done with mem_ready.
//  - B (Op=10): BRANCH one cycle, Branch=1, ALUSrcB=01, ResultSrc=10; 3-cycle instruction.
//  - MEM_TIMEOUT=4, ready=0 from reset release: FAULT (state=15) after 4 FETCH cycles, fault sticky, mem_req=0.
//  - Op=11: illegal pulse in DECODE, back to FETCH; reset low mid-MEMREAD: FETCH at once, all strobes 0.

Source files
------------

// File: rtl/arm_mc_fsm.sv
// rtl/arm_mc_fsm.sv - multicycle ARM main sequencing FSM with memory-ready wait timeout
module arm_mc_fsm #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IRWrite,
  output logic       NextPC,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       RegW,
  output logic       MemW,
  output logic       Branch,
  output logic       instr_done,
  output logic       illegal,
  output logic       fault,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWRITE = 4'd4,
    S_MEMWB    = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_FAULT    = 4'd15
  } state_t;

  // A one-bit counter is kept when the timeout is disabled so the width stays legal.
  localparam int            CW        = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

  state_t        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          mem_state;
  logic          timeout_hit;

  logic       mem_req_c, ir_write_c, next_pc_c, adr_src_c, alu_src_a_c;
  logic [1:0] alu_src_b_c, result_src_c;
  logic       alu_op_c, reg_w_c, mem_w_c, branch_c, instr_done_c, illegal_c, fault_c;

  logic unused_funct;
  assign unused_funct = ^Funct[4:1];

  always_comb begin
    mem_state   = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    timeout_hit = (MEM_TIMEOUT > 0) && mem_state && !mem_ready && (wait_cnt_q == CNT_LIMIT);

    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_MEMWB:    state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_FAULT:    state_d = S_FAULT;
      default:    state_d = S_FAULT;
    endcase
    if (timeout_hit) state_d = S_FAULT;

    // Any state change clears the counter, which covers every entry into a memory state.
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (mem_state && !mem_ready && (wait_cnt_q != CNT_MAX)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_comb begin
    mem_req_c    = 1'b0;
    ir_write_c   = 1'b0;
    next_pc_c    = 1'b0;
    adr_src_c    = 1'b0;
    alu_src_a_c  = 1'b0;
    alu_src_b_c  = 2'b00;
    result_src_c = 2'b00;
    alu_op_c     = 1'b0;
    reg_w_c      = 1'b0;
    mem_w_c      = 1'b0;
    branch_c     = 1'b0;
    instr_done_c = 1'b0;
    illegal_c    = 1'b0;
    fault_c      = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_c    = 1'b1;
        ir_write_c   = mem_ready;
        next_pc_c    = mem_ready;
        alu_src_a_c  = 1'b1;
        alu_src_b_c  = 2'b10;
        result_src_c = 2'b10;
      end
      S_DECODE: begin
        alu_src_a_c  = 1'b1;
        alu_src_b_c  = 2'b10;
        result_src_c = 2'b10;
        illegal_c    = (Op == 2'b11);
      end
      S_MEMADR:   alu_src_b_c = 2'b01;
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        adr_src_c = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req_c    = 1'b1;
        adr_src_c    = 1'b1;
        mem_w_c      = 1'b1;
        instr_done_c = mem_ready;
      end
      S_MEMWB: begin
        result_src_c = 2'b01;
        reg_w_c      = 1'b1;
        instr_done_c = 1'b1;
      end
      S_EXECR:    alu_op_c = 1'b1;
      S_EXECI: begin
        alu_src_b_c = 2'b01;
        alu_op_c    = 1'b1;
      end
      S_ALUWB: begin
        reg_w_c      = 1'b1;
        instr_done_c = 1'b1;
      end
      S_BRANCH: begin
        alu_src_b_c  = 2'b01;
        result_src_c = 2'b10;
        branch_c     = 1'b1;
        instr_done_c = 1'b1;
      end
      S_FAULT:    fault_c = 1'b1;
      default:    fault_c = 1'b1;
    endcase
  end

  // Outputs are qualified by reset so the Mealy FETCH terms stay quiet while reset is held.
  assign mem_req    = reset & mem_req_c;
  assign IRWrite    = reset & ir_write_c;
  assign NextPC     = reset & next_pc_c;
  assign AdrSrc     = reset & adr_src_c;
  assign ALUSrcA    = reset & alu_src_a_c;
  assign ALUSrcB    = {2{reset}} & alu_src_b_c;
  assign ResultSrc  = {2{reset}} & result_src_c;
  assign ALUOp      = reset & alu_op_c;
  assign RegW       = reset & reg_w_c;
  assign MemW       = reset & mem_w_c;
  assign Branch     = reset & branch_c;
  assign instr_done = reset & instr_done_c;
  assign illegal    = reset & illegal_c;
  assign fault      = reset & fault_c;
  assign state      = state_q;

endmodule

// File: tb/tb_arm_mc_fsm.sv
// tb/tb_arm_mc_fsm.sv - directed scoreboard bench for arm_mc_fsm
module tb_arm_mc_fsm;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] Op = 2'b00;
  logic [5:0] Funct = 6'b000000;
  logic       mem_ready = 1'b0;
  logic       mem_req, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUOp, RegW, MemW, Branch;
  logic       instr_done, illegal, fault;
  logic [1:0] ALUSrcB, ResultSrc;
  logic [3:0] state;

  int vectors = 0;
  int miscompares = 0;

  arm_mc_fsm #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .mem_ready(mem_ready),
    .mem_req(mem_req), .IRWrite(IRWrite), .NextPC(NextPC), .AdrSrc(AdrSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ALUOp(ALUOp),
    .RegW(RegW), .MemW(MemW), .Branch(Branch), .instr_done(instr_done),
    .illegal(illegal), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  // {mem_req,IRWrite,NextPC,AdrSrc,ALUSrcA,ALUSrcB,ResultSrc,ALUOp,RegW,MemW,Branch,done,illegal,fault}
  localparam logic [15:0] V_ZERO     = 16'h0000;
  localparam logic [15:0] V_FETCH_W  = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 7'b0000000};
  localparam logic [15:0] V_FETCH_R  = {1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 2'b10, 7'b0000000};
  localparam logic [15:0] V_DECODE   = {4'b0000, 1'b1, 2'b10, 2'b10, 7'b0000000};
  localparam logic [15:0] V_DEC_ILL  = {4'b0000, 1'b1, 2'b10, 2'b10, 7'b0000010};
  localparam logic [15:0] V_MEMADR   = {5'b00000, 2'b01, 2'b00, 7'b0000000};
  localparam logic [15:0] V_MEMREAD  = {1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 7'b0000000};
  localparam logic [15:0] V_MEMWB    = {5'b00000, 2'b00, 2'b01, 7'b0100100};
  localparam logic [15:0] V_MEMWR_W  = {1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 7'b0010000};
  localparam logic [15:0] V_MEMWR_R  = {1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 7'b0010100};
  localparam logic [15:0] V_EXECR    = {5'b00000, 2'b00, 2'b00, 7'b1000000};
  localparam logic [15:0] V_EXECI    = {5'b00000, 2'b01, 2'b00, 7'b1000000};
  localparam logic [15:0] V_ALUWB    = {5'b00000, 2'b00, 2'b00, 7'b0100100};
  localparam logic [15:0] V_BRANCH   = {5'b00000, 2'b01, 2'b10, 7'b0001100};
  localparam logic [15:0] V_FAULT    = 16'h0001;

  typedef struct {
    string       tag;
    logic [19:0] exp;
  } exp_t;

  exp_t sb[$];

  function automatic logic [19:0] observed();
    return {state, mem_req, IRWrite, NextPC, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
            ALUOp, RegW, MemW, Branch, instr_done, illegal, fault};
  endfunction

  task automatic check_now();
    exp_t        e;
    logic [19:0] obs;
    e   = sb.pop_front();
    obs = observed();
    vectors++;
    assert (obs === e.exp) else begin
      miscompares++;
      $error("FAIL %s: observed state=%0d outs=%h, expected state=%0d outs=%h",
             e.tag, obs[19:16], obs[15:0], e.exp[19:16], e.exp[15:0]);
    end
  endtask

  // Called at posedge+1: drive ready, predict, compare at negedge, advance one clock.
  task automatic step(input string tag, input logic rdy, input logic [3:0] st, input logic [15:0] v);
    exp_t e;
    mem_ready = rdy;
    e.tag = tag;
    e.exp = {st, v};
    sb.push_back(e);
    @(negedge clk);
    check_now();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [1:0] op, input logic [5:0] fn);
    Op    = op;
    Funct = fn;
  endtask

  initial begin
    exp_t e;
    #12;
    e.tag = "reset_hold";
    e.exp = {4'd0, V_ZERO};
    sb.push_back(e);
    mem_ready = 1'b1;
    check_now();
    @(posedge clk);
    #1;
    reset = 1'b1;

    set_instr(2'b00, 6'b001000);
    step("add_fetch", 1'b1, 4'd0, V_FETCH_R);
    step("add_decode", 1'b0, 4'd1, V_DECODE);
    step("add_execr", 1'b0, 4'd6, V_EXECR);
    step("add_aluwb", 1'b0, 4'd8, V_ALUWB);

    set_instr(2'b01, 6'b011001);
    step("ldr_fetch_wait", 1'b0, 4'd0, V_FETCH_W);
    step("ldr_fetch", 1'b1, 4'd0, V_FETCH_R);
    step("ldr_decode", 1'b0, 4'd1, V_DECODE);
    step("ldr_memadr", 1'b0, 4'd2, V_MEMADR);
    step("ldr_memread_w0", 1'b0, 4'd3, V_MEMREAD);
    step("ldr_memread_w1", 1'b0, 4'd3, V_MEMREAD);
    step("ldr_memread_w2", 1'b0, 4'd3, V_MEMREAD);
    step("ldr_memread_rdy", 1'b1, 4'd3, V_MEMREAD);
    step("ldr_memwb", 1'b0, 4'd5, V_MEMWB);

    set_instr(2'b01, 6'b011000);
    step("str_fetch", 1'b1, 4'd0, V_FETCH_R);
    step("str_decode", 1'b0, 4'd1, V_DECODE);
    step("str_memadr", 1'b0, 4'd2, V_MEMADR);
    step("str_memwrite_w0", 1'b0, 4'd4, V_MEMWR_W);
    step("str_memwrite_w1", 1'b0, 4'd4, V_MEMWR_W);
    step("str_memwrite_rdy", 1'b1, 4'd4, V_MEMWR_R);

    set_instr(2'b10, 6'b000000);
    step("b_fetch", 1'b1, 4'd0, V_FETCH_R);
    step("b_decode", 1'b0, 4'd1, V_DECODE);
    step("b_branch", 1'b0, 4'd9, V_BRANCH);

    set_instr(2'b11, 6'b000000);
    step("ill_fetch", 1'b1, 4'd0, V_FETCH_R);
    step("ill_decode", 1'b0, 4'd1, V_DEC_ILL);

    set_instr(2'b00, 6'b101000);
    step("addi_fetch", 1'b1, 4'd0, V_FETCH_R);
    step("addi_decode", 1'b0, 4'd1, V_DECODE);
    step("addi_execi", 1'b0, 4'd7, V_EXECI);
    step("addi_aluwb", 1'b0, 4'd8, V_ALUWB);

    set_instr(2'b01, 6'b011001);
    step("rst_fetch", 1'b1, 4'd0, V_FETCH_R);
    step("rst_decode", 1'b0, 4'd1, V_DECODE);
    step("rst_memadr", 1'b0, 4'd2, V_MEMADR);
    step("rst_memread", 1'b0, 4'd3, V_MEMREAD);
    mem_ready = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    e.tag = "rst_async";
    e.exp = {4'd0, V_ZERO};
    sb.push_back(e);
    check_now();
    @(posedge clk);
    #1;
    reset = 1'b1;
    step("rst_refetch", 1'b1, 4'd0, V_FETCH_R);

    reset = 1'b0;
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    reset = 1'b1;
    step("to_fetch0", 1'b0, 4'd0, V_FETCH_W);
    step("to_fetch1", 1'b0, 4'd0, V_FETCH_W);
    step("to_fetch2", 1'b0, 4'd0, V_FETCH_W);
    step("to_fetch3", 1'b0, 4'd0, V_FETCH_W);
    step("to_fault0", 1'b1, 4'd15, V_FAULT);
    step("to_fault1", 1'b1, 4'd15, V_FAULT);
    step("to_fault2", 1'b0, 4'd15, V_FAULT);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
